// File: rtl/periph_reg_hub.sv
// Register-bus hub: fans one reg-bus master out to NCH peripheral channels,
// with ack timeout, unmapped-address errors and a local CSR/interrupt window.
module periph_reg_hub #(
    parameter int NCH     = 5,
    parameter int SEL_W   = 3,
    parameter int SUB_AW  = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                    app_clk,
    input  logic                    app_rst,
    input  logic                    reg_cs,
    input  logic                    reg_wr,
    input  logic [SEL_W+SUB_AW-1:0] reg_addr,
    input  logic [31:0]             reg_wdata,
    input  logic [3:0]              reg_be,
    output logic [31:0]             reg_rdata,
    output logic                    reg_ack,
    output logic                    reg_err,
    output logic [NCH-1:0]          ch_cs,
    output logic                    ch_wr,
    output logic [SUB_AW-1:0]       ch_addr,
    output logic [31:0]             ch_wdata,
    output logic [3:0]              ch_be,
    input  logic [NCH*32-1:0]       ch_rdata,
    input  logic [NCH-1:0]          ch_ack,
    input  logic [NCH-1:0]          ch_irq,
    output logic                    irq_o
);
    localparam int AW = SEL_W + SUB_AW;
    localparam logic [SEL_W-1:0] CSR_SEL = '1;
    localparam logic [SEL_W-1:0] NCH_SEL = SEL_W'(NCH);
    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel, sel_q;
    logic [7:0]       timer, tocnt;
    logic [NCH-1:0]   irq_mask;
    logic             err_to, err_um;
    logic [2:0]       err_ch;
    logic [31:0]      csr_rd, ch_rd_sel;
    logic             ack_sel;
    logic [1:0]       csr_idx;
    logic             csr_hit;

    assign sel     = reg_addr[AW-1:SUB_AW];
    assign csr_idx = reg_addr[3:2];
    assign csr_hit = (reg_addr[SUB_AW-1:4] == '0);

    always_comb begin
        csr_rd = '0;
        if (csr_hit) begin
            case (csr_idx)
                2'd0: csr_rd[NCH-1:0] = ch_irq;
                2'd1: csr_rd[NCH-1:0] = irq_mask;
                2'd2: begin
                    csr_rd[10:8] = err_ch;
                    csr_rd[1:0]  = {err_um, err_to};
                end
                default: csr_rd[7:0] = tocnt;
            endcase
        end
    end

    // Only the selected channel's ack and data are ever looked at.
    always_comb begin
        ch_rd_sel = '0;
        ack_sel   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ch_rd_sel = ch_rdata[32*i +: 32];
                ack_sel   = ch_ack[i];
            end
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            timer     <= '0;
            tocnt     <= '0;
            irq_mask  <= '0;
            err_to    <= 1'b0;
            err_um    <= 1'b0;
            err_ch    <= '0;
            reg_rdata <= '0;
            reg_ack   <= 1'b0;
            reg_err   <= 1'b0;
            ch_cs     <= '0;
            ch_wr     <= 1'b0;
            ch_addr   <= '0;
            ch_wdata  <= '0;
            ch_be     <= '0;
            irq_o     <= 1'b0;
        end else begin
            irq_o   <= |(ch_irq & irq_mask);
            reg_ack <= 1'b0;
            case (state)
                IDLE: if (reg_cs) begin
                    ch_wr    <= reg_wr;
                    ch_addr  <= reg_addr[SUB_AW-1:0];
                    ch_wdata <= reg_wdata;
                    ch_be    <= reg_be;
                    sel_q    <= sel;
                    if (sel < NCH_SEL) begin
                        ch_cs <= NCH'(1) << sel;
                        timer <= '0;
                        state <= BUSY;
                    end else if (sel == CSR_SEL) begin
                        reg_ack   <= 1'b1;
                        reg_err   <= 1'b0;
                        reg_rdata <= csr_rd;
                        state     <= RESP;
                        if (reg_wr && csr_hit) begin
                            case (csr_idx)
                                2'd1: if (reg_be[0]) irq_mask <= reg_wdata[NCH-1:0];
                                2'd2: if (reg_be[0]) begin
                                    err_to <= err_to & ~reg_wdata[0];
                                    err_um <= err_um & ~reg_wdata[1];
                                end
                                2'd3: tocnt <= '0;
                                default: ;
                            endcase
                        end
                    end else begin
                        reg_ack   <= 1'b1;
                        reg_err   <= 1'b1;
                        reg_rdata <= '1;
                        err_um    <= 1'b1;
                        state     <= RESP;
                    end
                end
                BUSY: begin
                    timer <= timer + 8'd1;
                    // An ack in the final timeout cycle still completes normally.
                    if (ack_sel) begin
                        ch_cs     <= '0;
                        reg_ack   <= 1'b1;
                        reg_err   <= 1'b0;
                        reg_rdata <= ch_rd_sel;
                        state     <= RESP;
                    end else if (timer == TO_LAST) begin
                        ch_cs     <= '0;
                        reg_ack   <= 1'b1;
                        reg_err   <= 1'b1;
                        reg_rdata <= '1;
                        err_to    <= 1'b1;
                        err_ch    <= 3'(sel_q);
                        if (tocnt != 8'hFF) tocnt <= tocnt + 8'd1;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_periph_reg_hub.sv
// Scoreboard bench for periph_reg_hub: stimulus pushes expected responses,
// a negedge monitor pops and compares on every reg_ack.
module tb_periph_reg_hub;
    localparam int NCH = 5;

    logic               app_clk = 1'b0;
    logic               app_rst;
    logic               reg_cs;
    logic               reg_wr;
    logic [8:0]         reg_addr;
    logic [31:0]        reg_wdata;
    logic [3:0]         reg_be;
    logic [31:0]        reg_rdata;
    logic               reg_ack;
    logic               reg_err;
    logic [NCH-1:0]     ch_cs;
    logic               ch_wr;
    logic [5:0]         ch_addr;
    logic [31:0]        ch_wdata;
    logic [3:0]         ch_be;
    logic [NCH*32-1:0]  ch_rdata;
    logic [NCH-1:0]     ch_ack;
    logic [NCH-1:0]     ch_irq;
    logic               irq_o;

    periph_reg_hub #(.NCH(NCH), .SEL_W(3), .SUB_AW(6), .TIMEOUT(64)) dut (
        .app_clk(app_clk), .app_rst(app_rst),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err),
        .ch_cs(ch_cs), .ch_wr(ch_wr), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_be(ch_be),
        .ch_rdata(ch_rdata), .ch_ack(ch_ack), .ch_irq(ch_irq), .irq_o(irq_o)
    );

    always #5 app_clk = ~app_clk;

    typedef struct packed {
        logic        chk;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   run = 0;
    int   last_run = 0;
    bit   cs_seen = 0;

    localparam logic [8:0] A_RAW = 9'h1C0, A_MASK = 9'h1C4, A_ERR = 9'h1C8, A_TOC = 9'h1CC;

    // Response monitor
    always @(negedge app_clk) begin
        exp_t e;
        if (reg_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: got rdata=%h err=%b, none expected", reg_rdata, reg_err);
            end else begin
                e = exp_q.pop_front();
                if (reg_err !== e.err || (e.chk && reg_rdata !== e.rd)) begin
                    bad++;
                    $display("FAIL resp: got rdata=%h err=%b, want rdata=%h err=%b",
                             reg_rdata, reg_err, e.rd, e.err);
                end
            end
        end
    end

    // Channel-select run-length tracker
    always @(negedge app_clk) begin
        if (ch_cs != '0) begin
            run++;
            cs_seen = 1;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    task automatic issue(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic chk, input logic [31:0] rd,
                         input logic err);
        exp_q.push_back({chk, err, rd});
        reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
        @(posedge app_clk); #1;
        reg_cs = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge app_clk);
            if (reg_ack) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no reg_ack, want one within %0d cycles", budget);
        end
        @(posedge app_clk); #1;
    endtask

    task automatic csr_rd(input logic [8:0] addr, input logic [31:0] want);
        issue(1'b0, addr, 32'h0, 4'hF, 1'b1, want, 1'b0);
        wait_ack(4);
    endtask

    task automatic csr_wr(input logic [8:0] addr, input logic [31:0] wd, input logic [3:0] be);
        issue(1'b1, addr, wd, be, 1'b0, 32'h0, 1'b0);
        wait_ack(4);
    endtask

    initial begin
        app_rst = 1'b1; reg_cs = 0; reg_wr = 0; reg_addr = '0; reg_wdata = '0; reg_be = '0;
        ch_ack = '0; ch_irq = '0;
        for (int i = 0; i < NCH; i++) ch_rdata[32*i +: 32] = 32'hC0DE0000 + i;
        ch_rdata[32*2 +: 32] = 32'h1234_5678;
        ch_rdata[32*3 +: 32] = 32'h3333_3333;
        repeat (3) @(posedge app_clk);
        #1 app_rst = 1'b0;

        check("reset_ack_err_irq", {29'b0, reg_ack, reg_err, irq_o}, 32'h0);
        check("reset_rdata", reg_rdata, 32'h0);
        check("reset_ch_ctl", {22'b0, ch_cs, ch_wr, ch_addr}, 32'h0);
        check("reset_ch_data", ch_wdata | {28'b0, ch_be}, 32'h0);

        // Unmapped sel=5: latency 1, error, no channel select
        cs_seen = 0;
        issue(1'b0, 9'h140, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("unmapped_latency", {31'b0, reg_ack}, 32'h1);
        wait_ack(2);
        check("unmapped_no_cs", {31'b0, cs_seen}, 32'h0);
        csr_rd(A_ERR, 32'h0000_0002);
        csr_wr(A_ERR, 32'h3, 4'b1110);
        csr_rd(A_ERR, 32'h0000_0002);
        csr_wr(A_ERR, 32'h3, 4'hF);
        csr_rd(A_ERR, 32'h0);

        // Channel 2 read, acked 3 cycles after ch_cs rises
        issue(1'b0, 9'h084, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0);
        check("ch2_addr", {26'b0, ch_addr}, 32'h04);
        check("ch2_cs", {27'b0, ch_cs}, 32'h04);
        repeat (2) begin @(posedge app_clk); #1; end
        ch_ack = 5'b00100;
        @(posedge app_clk); #1;
        ch_ack = '0;
        wait_ack(4);
        check("ch2_cs_cycles", last_run, 3);

        // Channel 4 write, never acked: timeout
        issue(1'b1, 9'h100, 32'hAA55_0F0F, 4'h3, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("ch4_wdata", ch_wdata, 32'hAA55_0F0F);
        check("ch4_wr_be", {27'b0, ch_wr, ch_be}, 32'h13);
        wait_ack(100);
        check("timeout_cs_cycles", last_run, 64);
        csr_rd(A_ERR, 32'h0000_0401);
        csr_rd(A_TOC, 32'h1);

        // Ack in the final cycle wins
        issue(1'b0, 9'h100, 32'h0, 4'hF, 1'b1, 32'hC0DE_0004, 1'b0);
        repeat (63) begin @(posedge app_clk); #1; end
        ch_ack = 5'b10000;
        @(posedge app_clk); #1;
        ch_ack = '0;
        wait_ack(4);
        check("late_ack_cs_cycles", last_run, 64);
        csr_rd(A_TOC, 32'h1);
        csr_wr(A_TOC, 32'h0, 4'h0);
        csr_rd(A_TOC, 32'h0);

        // Interrupt masking
        ch_irq = 5'b10010;
        csr_wr(A_MASK, 32'h2, 4'h1);
        check("irq_on", {31'b0, irq_o}, 32'h1);
        csr_wr(A_MASK, 32'h1, 4'h1);
        check("irq_off", {31'b0, irq_o}, 32'h0);
        csr_rd(A_RAW, 32'h12);
        csr_wr(A_MASK, 32'h1F, 4'h0);
        csr_rd(A_MASK, 32'h01);
        csr_rd(9'h1D0, 32'h0);

        // Reset two cycles into a channel-1 access
        issue(1'b0, 9'h040, 32'h0, 4'hF, 1'b1, 32'hC0DE_0001, 1'b0);
        @(posedge app_clk); #1;
        app_rst = 1'b1;
        @(posedge app_clk); #1;
        app_rst = 1'b0;
        void'(exp_q.pop_back());
        check("rst_busy_cs", {27'b0, ch_cs}, 32'h0);
        ch_ack = 5'b00010;
        @(posedge app_clk); #1;
        ch_ack = '0;
        repeat (3) begin @(posedge app_clk); #1; end
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        csr_rd(A_MASK, 32'h0);
        issue(1'b0, 9'h040, 32'h0, 4'hF, 1'b1, 32'hC0DE_0001, 1'b0);
        ch_ack = 5'b00010;
        @(posedge app_clk); #1;
        ch_ack = '0;
        check("min_latency_ack", {31'b0, reg_ack}, 32'h1);
        wait_ack(2);

        // Held reg_cs across CSR reads: one ack every two cycles
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 1'b0, 32'h12});
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = A_RAW; reg_be = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            @(posedge app_clk); #1;
            if (k == 5) reg_cs = 1'b0;
            @(negedge app_clk);
            check($sformatf("b2b_ack_%0d", k), {31'b0, reg_ack}, {31'b0, k[0]});
        end
        @(posedge app_clk); #1;

        // Stray ack from channel 0 during a channel-3 access
        issue(1'b0, 9'h0C0, 32'h0, 4'hF, 1'b1, 32'h3333_3333, 1'b0);
        ch_ack = 5'b00001;
        @(posedge app_clk); #1;
        ch_ack = '0;
        @(posedge app_clk); #1;
        ch_ack = 5'b01000;
        @(posedge app_clk); #1;
        ch_ack = '0;
        wait_ack(4);
        check("stray_cs_cycles", last_run, 3);

        repeat (3) @(posedge app_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
